// File: rtl/dsw_debounce.sv
// dsw_debounce: synchronise and debounce three 8-bit DIP switch banks against a shared sample tick,
// with a registered per-bank change pulse.
module dsw_debounce #(
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dsw0,
    input  logic [7:0] dsw1,
    input  logic [7:0] dsw2,
    output logic [7:0] db0,
    output logic [7:0] db1,
    output logic [7:0] db2,
    output logic [2:0] chg,
    output logic       tick
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic [PW-1:0]        pre_q, pre_d;
    logic                 tick_q;
    logic [23:0]          meta_q, sync_q, db_q, db_d;
    logic [23:0][CW-1:0]  ctr_q, ctr_d;
    logic [2:0]           chg_q, chg_d;

    assign pre_d = (pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + 1'b1;

    always_comb begin
        db_d  = db_q;
        ctr_d = ctr_q;
        for (int i = 0; i < 24; i++) begin
            if (tick_q) begin
                if (sync_q[i] == db_q[i]) begin
                    ctr_d[i] = '0;
                end else if (ctr_q[i] == CW'(STABLE_TICKS - 1)) begin
                    ctr_d[i] = '0;
                    db_d[i]  = sync_q[i];
                end else begin
                    ctr_d[i] = ctr_q[i] + 1'b1;
                end
            end
        end
    end

    assign chg_d = {|(db_d[23:16] ^ db_q[23:16]), |(db_d[15:8] ^ db_q[15:8]), |(db_d[7:0] ^ db_q[7:0])};

    // tick_q is registered from the next prescaler value so it is high exactly while the count sits at TICK_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            meta_q <= '0;
            sync_q <= '0;
            db_q   <= '0;
            ctr_q  <= '0;
            chg_q  <= '0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_d == PW'(TICK_DIV - 1));
            meta_q <= {dsw2, dsw1, dsw0};
            sync_q <= meta_q;
            db_q   <= db_d;
            ctr_q  <= ctr_d;
            chg_q  <= chg_d;
        end
    end

    assign db0  = db_q[7:0];
    assign db1  = db_q[15:8];
    assign db2  = db_q[23:16];
    assign chg  = chg_q;
    assign tick = tick_q;
endmodule
